vga_rx_timing: RTL and testbench

VGA_RX_TIMING -- requirements
Module: vga_rx_timing

---
 rtl/vga_rx_timing.sv | 219 +++++++++++++++++++++
 tb/tb_vga_rx_timing.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_timing.sv
// Recovers raster timing from an incoming sync/blank/RGB stream, locks onto a stable
// line/frame geometry and re-emits active pixels tagged with their column and line.
module vga_rx_timing #(
  parameter bit HS_ACTIVE_LOW = 1'b1,
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic [10:0] h_active,
  output logic        sync_err
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, VERIFY = 2'd2, LOCKED = 2'd3} state_e;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  // Syncs are normalised to "1 = asserted" before the input register.
  logic hsAsserted, vsAsserted;
  assign hsAsserted = HS_ACTIVE_LOW ? ~hsync_in : hsync_in;
  assign vsAsserted = VS_ACTIVE_LOW ? ~vsync_in : vsync_in;

  logic       hs_q, vs_q, hsDly_q, vsDly_q, blank_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hsDly_q <= 1'b0;
      vsDly_q <= 1'b0;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hs_q    <= hsAsserted;
      vs_q    <= vsAsserted;
      hsDly_q <= hs_q;
      vsDly_q <= vs_q;
      blank_q <= blank_in;
      r_q     <= r_in;
      g_q     <= g_in;
      b_q     <= b_in;
    end
  end

  logic hsEdge, vsEdge;
  assign hsEdge = hs_q & ~hsDly_q;
  assign vsEdge = vs_q & ~vsDly_q;

  logic [10:0] hCnt_q, hCnt_d, xCnt_q, xCnt_d, yCnt_q, yCnt_d, lCnt_q, lCnt_d;
  logic [10:0] lastLen_q, lastLen_d, lastActive_q, lastActive_d;
  logic [10:0] xBase, vCand, lenNow, activeNow;
  logic [11:0] lineLen;
  logic        hSat, lineHadActive;

  // A coincident hsync edge still closes the old frame's last line, so it is
  // folded into the line count before vsync restarts it.
  always_comb begin
    hSat          = (hCnt_q == CNT_MAX);
    lineLen       = {1'b0, hCnt_q} + 12'd1;
    lineHadActive = (xCnt_q != 11'd0);
    hCnt_d        = hsEdge ? 11'd0 : (hSat ? hCnt_q : hCnt_q + 11'd1);
    xBase         = hsEdge ? 11'd0 : xCnt_q;
    xCnt_d        = xBase;
    if (blank_q && (xBase != CNT_MAX)) begin
      xCnt_d = xBase + 11'd1;
    end
    yCnt_d = yCnt_q;
    if (vsEdge) begin
      yCnt_d = 11'd0;
    end else if (hsEdge && lineHadActive && (yCnt_q != CNT_MAX)) begin
      yCnt_d = yCnt_q + 11'd1;
    end
    vCand = (hsEdge && (lCnt_q != CNT_MAX)) ? lCnt_q + 11'd1 : lCnt_q;
    lCnt_d = vsEdge ? 11'd0 : vCand;
    lenNow       = hsEdge ? lineLen[10:0] : lastLen_q;
    activeNow    = (hsEdge && lineHadActive) ? xCnt_q : lastActive_q;
    lastLen_d    = lenNow;
    lastActive_d = activeNow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hCnt_q       <= '0;
      xCnt_q       <= '0;
      yCnt_q       <= '0;
      lCnt_q       <= '0;
      lastLen_q    <= '0;
      lastActive_q <= '0;
    end else begin
      hCnt_q       <= hCnt_d;
      xCnt_q       <= xCnt_d;
      yCnt_q       <= yCnt_d;
      lCnt_q       <= lCnt_d;
      lastLen_q    <= lastLen_d;
      lastActive_q <= lastActive_d;
    end
  end

  state_e state_q, state_d;
  logic   geomMatch, lockLost;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  logic [10:0] hTotal_q, vTotal_q, hActive_q;

  always_comb begin
    geomMatch = (lenNow == hTotal_q) && (activeNow == hActive_q) && (vCand == vTotal_q);
    lockLost  = hSat || (hsEdge && (lineLen != {1'b0, hTotal_q})) || (vsEdge && (vCand != vTotal_q));
    state_d   = state_q;
    unique case (state_q)
      SEARCH:  if (vsEdge) state_d = MEASURE;
      MEASURE: begin
        if (hSat) state_d = SEARCH;
        else if (vsEdge) state_d = VERIFY;
      end
      VERIFY: begin
        if (hSat) state_d = SEARCH;
        else if (vsEdge && geomMatch) state_d = LOCKED;
      end
      LOCKED:  if (lockLost) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  logic syncErrNow, captureEn, pixNow;

  // A VERIFY frame that did not promote to LOCKED recaptures the new geometry.
  always_comb begin
    locked     = (state_q == LOCKED);
    syncErrNow = (state_q == LOCKED) && (state_d == SEARCH);
    captureEn  = vsEdge && (state_d == VERIFY) && ((state_q == MEASURE) || (state_q == VERIFY));
    pixNow     = (state_q == LOCKED) && blank_q;
  end

  logic        p2Valid_q, pixValid_q, frameStart_q, syncErr_q;
  logic [9:0]  p2X_q, p2Y_q, pixX_q, pixY_q;
  logic [7:0]  p2R_q, p2G_q, p2B_q, pixR_q, pixG_q, pixB_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hTotal_q     <= '0;
      vTotal_q     <= '0;
      hActive_q    <= '0;
      p2Valid_q    <= 1'b0;
      p2X_q        <= '0;
      p2Y_q        <= '0;
      p2R_q        <= '0;
      p2G_q        <= '0;
      p2B_q        <= '0;
      pixValid_q   <= 1'b0;
      pixX_q       <= '0;
      pixY_q       <= '0;
      pixR_q       <= '0;
      pixG_q       <= '0;
      pixB_q       <= '0;
      frameStart_q <= 1'b0;
      syncErr_q    <= 1'b0;
    end else begin
      if (captureEn) begin
        hTotal_q  <= lenNow;
        vTotal_q  <= vCand;
        hActive_q <= activeNow;
      end
      p2Valid_q    <= pixNow;
      p2X_q        <= xBase[9:0];
      p2Y_q        <= yCnt_d[9:0];
      p2R_q        <= r_q;
      p2G_q        <= g_q;
      p2B_q        <= b_q;
      pixValid_q   <= p2Valid_q;
      frameStart_q <= vsEdge;
      syncErr_q    <= syncErrNow;
      if (p2Valid_q) begin
        pixX_q <= p2X_q;
        pixY_q <= p2Y_q;
        pixR_q <= p2R_q;
        pixG_q <= p2G_q;
        pixB_q <= p2B_q;
      end
    end
  end

  assign pix_valid   = pixValid_q;
  assign pix_x       = pixX_q;
  assign pix_y       = pixY_q;
  assign pix_r       = pixR_q;
  assign pix_g       = pixG_q;
  assign pix_b       = pixB_q;
  assign frame_start = frameStart_q;
  assign sync_err    = syncErr_q;
  assign h_total     = hTotal_q;
  assign v_total     = vTotal_q;
  assign h_active    = hActive_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing on a reduced raster (40 clk/line, 32 active,
// 30 lines/frame, 24 active); a second instance sees positive-polarity hsync.
module tb_vga_rx_timing;

  localparam int LINE_LEN    = 40;
  localparam int H_ACT       = 32;
  localparam int HS_START    = 34;
  localparam int HS_END      = 38;
  localparam int FRAME_LINES = 30;
  localparam int V_ACT       = 24;
  localparam int VS_LINE     = 26;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsyncIn = 1'b1, hsyncInB = 1'b0, vsyncIn = 1'b1, blankIn = 1'b0;
  logic [7:0]  rIn = '0, gIn = '0, bIn = '0;

  logic        pix_valid, frame_start, locked, sync_err;
  logic [9:0]  pix_x, pix_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [10:0] h_total, v_total, h_active;

  logic        pixValidB, frameStartB, lockedB, syncErrB;
  logic [9:0]  pixXB, pixYB;
  logic [7:0]  pixRB, pixGB, pixBB;
  logic [10:0] hTotalB, vTotalB, hActiveB;

  int vectors = 0;
  int miscompares = 0;
  int syncErrCnt = 0;
  int syncErrCntB = 0;
  int frameCnt = 0;
  bit lockedSeen = 1'b0;

  always #5 clk = ~clk;

  vga_rx_timing dut (
    .clk(clk), .rst(rst), .hsync_in(hsyncIn), .vsync_in(vsyncIn), .blank_in(blankIn),
    .r_in(rIn), .g_in(gIn), .b_in(bIn),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total), .h_active(h_active), .sync_err(sync_err)
  );

  vga_rx_timing #(.HS_ACTIVE_LOW(1'b0)) dutPosH (
    .clk(clk), .rst(rst), .hsync_in(hsyncInB), .vsync_in(vsyncIn), .blank_in(blankIn),
    .r_in(rIn), .g_in(gIn), .b_in(bIn),
    .pix_valid(pixValidB), .pix_x(pixXB), .pix_y(pixYB),
    .pix_r(pixRB), .pix_g(pixGB), .pix_b(pixBB),
    .frame_start(frameStartB), .locked(lockedB),
    .h_total(hTotalB), .v_total(vTotalB), .h_active(hActiveB), .sync_err(syncErrB)
  );

  // Pulse outputs are tallied away from the active edge.
  always @(negedge clk) begin
    if (sync_err === 1'b1) syncErrCnt++;
    if (syncErrB === 1'b1) syncErrCntB++;
    if (frame_start === 1'b1) frameCnt++;
    if (locked === 1'b1) lockedSeen = 1'b1;
  end

  // Vsync edges coincide with an hsync edge at (VS_LINE, HS_START).
  task automatic drivePixRgb(input int line, input int h, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
    logic hs, vs;
    hs = (h >= HS_START) && (h < HS_END);
    vs = ((line == VS_LINE) && (h >= HS_START)) || (line == VS_LINE + 1) ||
         ((line == VS_LINE + 2) && (h < HS_START));
    hsyncIn  = ~hs;
    hsyncInB = hs;
    vsyncIn  = ~vs;
    blankIn  = (line < V_ACT) && (h < H_ACT);
    rIn = r;
    gIn = g;
    bIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drivePix(input int line, input int h);
    logic [7:0] hv, lv;
    hv = h[7:0];
    lv = line[7:0];
    drivePixRgb(line, h, hv, lv, 8'h5A);
  endtask

  task automatic driveIdle(input int n);
    for (int i = 0; i < n; i++) begin
      hsyncIn  = 1'b1;
      hsyncInB = 1'b0;
      vsyncIn  = 1'b1;
      blankIn  = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runLines(input int firstLine, input int lastLine, input int shortLine);
    for (int ln = firstLine; ln <= lastLine; ln++) begin
      for (int h = 0; h < ((ln == shortLine) ? LINE_LEN - 1 : LINE_LEN); h++) drivePix(ln, h);
    end
  endtask

  task automatic runFrame(input int lines, input int shortLine);
    runLines(0, lines - 1, shortLine);
  endtask

  task automatic doReset();
    rst = 1'b1;
    driveIdle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pix_valid: got %0b want 0", pix_valid); end
    vectors++; if ({pix_x, pix_y} !== 20'd0) begin miscompares++; $display("[TB] FAIL reset_pix_xy: got %0d/%0d want 0/0", pix_x, pix_y); end
    vectors++; if ({pix_r, pix_g, pix_b} !== 24'd0) begin miscompares++; $display("[TB] FAIL reset_pix_rgb: got %h want 000000", {pix_r, pix_g, pix_b}); end
    vectors++; if ({frame_start, locked, sync_err} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", {frame_start, locked, sync_err}); end
    vectors++; if ({h_total, v_total, h_active} !== 33'd0) begin miscompares++; $display("[TB] FAIL reset_geom: got %0d/%0d/%0d want 0/0/0", h_total, v_total, h_active); end
  endtask

  task automatic test_lock();
    int errBase, errBaseB, frameBase;
    doReset();
    errBase = syncErrCnt; errBaseB = syncErrCntB; frameBase = frameCnt;
    runFrame(FRAME_LINES, -1);
    runFrame(FRAME_LINES, -1);
    runLines(0, VS_LINE - 1, -1);
    for (int h = 0; h <= HS_START; h++) drivePix(VS_LINE, h);
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL lock_early: got %0b want 0", locked); end
    drivePix(VS_LINE, HS_START + 1);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL lock_third_vsync: got %0b want 1", locked); end
    vectors++; if (h_total !== 11'd40) begin miscompares++; $display("[TB] FAIL lock_h_total: got %0d want 40", h_total); end
    vectors++; if (v_total !== 11'd30) begin miscompares++; $display("[TB] FAIL lock_v_total: got %0d want 30", v_total); end
    vectors++; if (h_active !== 11'd32) begin miscompares++; $display("[TB] FAIL lock_h_active: got %0d want 32", h_active); end
    vectors++; if (lockedB !== 1'b1) begin miscompares++; $display("[TB] FAIL poshs_locked: got %0b want 1", lockedB); end
    vectors++; if ({hTotalB, vTotalB, hActiveB} !== {11'd40, 11'd30, 11'd32}) begin miscompares++; $display("[TB] FAIL poshs_geom: got %0d/%0d/%0d want 40/30/32", hTotalB, vTotalB, hActiveB); end
    driveIdle(2100);
    vectors++; if (syncErrCnt - errBase !== 1) begin miscompares++; $display("[TB] FAIL sat_sync_err: got %0d pulses want 1", syncErrCnt - errBase); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_unlocked: got %0b want 0", locked); end
    vectors++; if (syncErrCntB - errBaseB !== 1) begin miscompares++; $display("[TB] FAIL poshs_sat_err: got %0d pulses want 1", syncErrCntB - errBaseB); end
    vectors++; if (frameCnt - frameBase !== 3) begin miscompares++; $display("[TB] FAIL lock_frame_starts: got %0d want 3", frameCnt - frameBase); end
    vectors++; if (pixValidB !== 1'b0) begin miscompares++; $display("[TB] FAIL poshs_idle_valid: got %0b want 0", pixValidB); end
  endtask

  task automatic test_pixel();
    doReset();
    for (int f = 0; f < 3; f++) runFrame(FRAME_LINES, -1);
    drivePix(0, 0); drivePix(0, 1); drivePix(0, 2);
    vectors++; if ({pix_valid, pix_x, pix_y} !== {1'b1, 10'd0, 10'd0}) begin miscompares++; $display("[TB] FAIL first_pixel: got v=%0b x=%0d y=%0d want 1/0/0", pix_valid, pix_x, pix_y); end
    vectors++; if ({pix_r, pix_g, pix_b} !== 24'h00005A) begin miscompares++; $display("[TB] FAIL first_pixel_rgb: got %h want 00005a", {pix_r, pix_g, pix_b}); end
    for (int h = 3; h < LINE_LEN; h++) drivePix(0, h);
    runLines(1, V_ACT - 2, -1);
    for (int h = 0; h < H_ACT - 1; h++) drivePix(V_ACT - 1, h);
    drivePixRgb(V_ACT - 1, H_ACT - 1, 8'hF1, 8'hAA, 8'h39);
    drivePix(V_ACT - 1, H_ACT);
    vectors++; if ({pix_valid, pix_x} !== {1'b1, 10'd30}) begin miscompares++; $display("[TB] FAIL latency_prev_pixel: got v=%0b x=%0d want 1/30", pix_valid, pix_x); end
    drivePix(V_ACT - 1, H_ACT + 1);
    vectors++; if ({pix_valid, pix_x, pix_y} !== {1'b1, 10'd31, 10'd23}) begin miscompares++; $display("[TB] FAIL last_pixel_xy: got v=%0b x=%0d y=%0d want 1/31/23", pix_valid, pix_x, pix_y); end
    vectors++; if ({pix_r, pix_g, pix_b} !== 24'hF1AA39) begin miscompares++; $display("[TB] FAIL last_pixel_rgb: got %h want f1aa39", {pix_r, pix_g, pix_b}); end
    drivePix(V_ACT - 1, H_ACT + 2);
    vectors++; if ({pix_valid, pix_r, pix_g, pix_b} !== {1'b0, 24'hF1AA39}) begin miscompares++; $display("[TB] FAIL blank_hold: got v=%0b rgb=%h want 0/f1aa39", pix_valid, {pix_r, pix_g, pix_b}); end
    for (int h = H_ACT + 3; h < LINE_LEN; h++) drivePix(V_ACT - 1, h);
    runLines(V_ACT, FRAME_LINES - 1, -1);
  endtask

  task automatic test_short_line();
    int errBase;
    errBase = syncErrCnt;
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL short_pre_locked: got %0b want 1", locked); end
    runFrame(FRAME_LINES, 10);
    vectors++; if (syncErrCnt - errBase !== 1) begin miscompares++; $display("[TB] FAIL short_sync_err: got %0d pulses want 1", syncErrCnt - errBase); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("[TB] FAIL short_unlocked: got %0b want 0", locked); end
    for (int f = 0; f < 3; f++) runFrame(FRAME_LINES, -1);
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("[TB] FAIL short_relock: got %0b want 1", locked); end
    vectors++; if (syncErrCnt - errBase !== 1) begin miscompares++; $display("[TB] FAIL short_single_err: got %0d pulses want 1", syncErrCnt - errBase); end
  endtask

  task automatic test_alternating();
    int errBase, frameBase;
    doReset();
    lockedSeen = 1'b0;
    errBase = syncErrCnt; frameBase = frameCnt;
    for (int f = 0; f < 5; f++) runFrame(((f % 2) == 0) ? FRAME_LINES : FRAME_LINES + 1, -1);
    vectors++; if (lockedSeen !== 1'b0) begin miscompares++; $display("[TB] FAIL alt_never_locked: got %0b want 0", lockedSeen); end
    vectors++; if (syncErrCnt - errBase !== 0) begin miscompares++; $display("[TB] FAIL alt_no_sync_err: got %0d want 0", syncErrCnt - errBase); end
    vectors++; if (frameCnt - frameBase !== 5) begin miscompares++; $display("[TB] FAIL alt_frame_starts: got %0d want 5", frameCnt - frameBase); end
    vectors++; if (v_total !== 11'd31) begin miscompares++; $display("[TB] FAIL alt_v_total: got %0d want 31", v_total); end
  endtask

  task automatic test_reset_midline();
    int errBase;
    doReset();
    for (int f = 0; f < 3; f++) runFrame(FRAME_LINES, -1);
    runLines(0, 4, -1);
    for (int h = 0; h < 10; h++) drivePix(5, h);
    vectors++; if ({pix_valid, pix_x, pix_y, pix_r} !== {1'b1, 10'd7, 10'd5, 8'd7}) begin miscompares++; $display("[TB] FAIL midline_pre: got v=%0b x=%0d y=%0d r=%0d want 1/7/5/7", pix_valid, pix_x, pix_y, pix_r); end
    errBase = syncErrCnt;
    rst = 1'b1;
    drivePix(5, 10);
    rst = 1'b0;
    vectors++; if ({pix_valid, pix_x, pix_y} !== 21'd0) begin miscompares++; $display("[TB] FAIL midline_pix: got v=%0b x=%0d y=%0d want 0/0/0", pix_valid, pix_x, pix_y); end
    vectors++; if ({pix_r, pix_g, pix_b} !== 24'd0) begin miscompares++; $display("[TB] FAIL midline_rgb: got %h want 000000", {pix_r, pix_g, pix_b}); end
    vectors++; if ({locked, frame_start, sync_err} !== 3'b000) begin miscompares++; $display("[TB] FAIL midline_flags: got %b want 000", {locked, frame_start, sync_err}); end
    vectors++; if ({h_total, v_total, h_active} !== 33'd0) begin miscompares++; $display("[TB] FAIL midline_geom: got %0d/%0d/%0d want 0/0/0", h_total, v_total, h_active); end
    drivePix(5, 11);
    drivePix(5, 12);
    vectors++; if (syncErrCnt - errBase !== 0) begin miscompares++; $display("[TB] FAIL midline_no_err: got %0d pulses want 0", syncErrCnt - errBase); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixel();
    test_short_line();
    test_alternating();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
